// File: rtl/seq_mult_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
package seq_mult_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
   localparam int MAX_WIDTH = 32;
endpackage

// File: rtl/mux2.sv
// Two-input word multiplexer: y = s ? d1 : d0.
module mux2 #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic             s,
   output logic [WIDTH-1:0] y
);
   assign y = s ? d1 : d0;
endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-and-add unsigned multiplier, one multiplier bit per clock.
// Optional macro SEQ_MULT_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are zero.
module seq_mult_ctrl
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH+1);

   mult_state_t        state, state_n;
   logic [WIDTH-1:0]   a, a_n, q, q_n, m, m_n;
   logic [CW-1:0]      cnt, cnt_n;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] shifted, prod_n;
   logic               busy_n, done_n;
`ifdef SEQ_MULT_EARLY_TERM_EN
   logic [WIDTH-1:0]   rest;
`endif

   mux2 #(.WIDTH(WIDTH)) u_addend_mux (
      .d0 ('0),
      .d1 (m),
      .s  (q[0]),
      .y  (addend)
   );

   assign sum     = {1'b0, a} + {1'b0, addend};
   assign shifted = {sum, q[WIDTH-1:1]};

   always_comb begin
      state_n = state;
      a_n     = a;
      q_n     = q;
      m_n     = m;
      cnt_n   = cnt;
`ifdef SEQ_MULT_EARLY_TERM_EN
      rest    = '0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               a_n     = '0;
               q_n     = mplier;
               m_n     = mcand;
               cnt_n   = CW'(WIDTH);
               state_n = RUN;
            end
         end
         RUN: begin
            {a_n, q_n} = shifted;
            cnt_n      = cnt - 1'b1;
            if (cnt == CW'(1)) state_n = DONE;
`ifdef SEQ_MULT_EARLY_TERM_EN
            // Bit 0 is consumed this edge anyway; if every bit still pending above it is
            // zero, the remaining iterations are pure shifts and collapse into one.
            rest = (q >> 1) & ~({WIDTH{1'b1}} << (cnt - 1'b1));
            if (rest == '0) begin
               {a_n, q_n} = shifted >> (cnt - 1'b1);
               cnt_n      = '0;
               state_n    = DONE;
            end
`endif
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
      prod_n = product;
      // Capture the final {A,Q} on entry to DONE so product is valid alongside done.
      if (state == RUN && state_n == DONE) prod_n = {a_n, q_n};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         a       <= '0;
         q       <= '0;
         m       <= '0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
      end else begin
         state   <= state_n;
         a       <= a_n;
         q       <= q_n;
         m       <= m_n;
         cnt     <= cnt_n;
         busy    <= busy_n;
         done    <= done_n;
         product <= prod_n;
      end
   end
endmodule
